uart_receiver_with_peripheral: RTL and testbench
================================================

UART_RECEIVER_WITH_PERIPHERAL -- requirements
Module: uart_receiver_with_peripheral

Interface
REQ-001 The parameters SHALL be:
- DATA_WIDTH, 8: bits per frame.
- BIT_COUNTER_WIDTH, 3: width of the data-bit index, which counts 0..DATA_WIDTH-1.
- CLOCK_COUNTER_WIDTH, 21: width of the per-bit clock counter.
- CLOCKS_PER_BIT, 434: clocks per serial bit.
REQ-002 The ports SHALL be, clock and reset first:
- i_clock, in, 1: the single clock; all logic is on its rising edge.
- i_resetL, in, 1: reset, asynchronous and active-low.
- i_RX, in, 1: serial line; idle high, asynchronous to i_clock.
- o_data, out, DATA_WIDTH: last correctly framed byte.
- o_valid, out, 1: one-clock strobe for a new o_data.
- o_frame_error, out, 1: one-clock strobe for a bad stop bit.
- o_busy, out, 1: high whenever the FSM is not in IDLE.
- o_key_a, out, 1: one-hot flag for the last decoded key 'a'.
- o_key_s, out, 1: one-hot flag for 's'.
- o_key_d, out, 1: one-hot flag for 'd'.
- o_key_w, out, 1: one-hot flag for 'w'.

Function
REQ-003 i_RX SHALL pass through a 2-flop synchronizer; both flops reset to 1; all FSM decisions use the synchronized value (rx_s).
REQ-004 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-005 IDLE: if rx_s=0, go to START and clear the clock counter.
REQ-006 START: at clock count CLOCKS_PER_BIT/2-1 (216), sample rx_s.
- If rx_s=0, go to DATA with the clock counter and bit index cleared.
- If rx_s=1, treat it as a glitch and return to IDLE with no strobe.
REQ-007 DATA: at each clock count CLOCKS_PER_BIT-1 (433), shift rx_s into the shift register, LSB first, and clear the clock counter.
- After bit index DATA_WIDTH-1, go to STOP.
- Otherwise increment the bit index.
REQ-008 STOP: at clock count CLOCKS_PER_BIT-1, sample rx_s.
- If rx_s=1, load o_data from the shift register, pulse o_valid for exactly one clock, and go to IDLE.
- If rx_s=0, pulse o_frame_error for one clock, leave o_data and the key flags unchanged, and go to WAIT_HIGH.
REQ-009 WAIT_HIGH: stay until rx_s=1, then go to IDLE; a low line SHALL never start a new frame from this state.
REQ-010 Valid-frame latency: o_valid SHALL rise 2 + 216 + 8*434 + 434 clocks (±2) after the i_RX falling edge of the start bit, i.e. about 9.5 bit times.
REQ-011 Back-to-back frames with one stop bit SHALL be received without loss; the FSM is in IDLE at least one bit-half before the next start edge.
REQ-012 The clock counter SHALL be CLOCK_COUNTER_WIDTH bits, clear on every state change, and never wrap within a bit.
REQ-013 Key decode SHALL update in the same clock as o_valid:
- 0x61 sets o_key_a only.
- 0x73 sets o_key_s only.
- 0x64 sets o_key_d only.
- 0x77 sets o_key_w only.
- Any other byte clears all four flags.
- At most one flag is high at any time.
REQ-014 o_valid and o_frame_error SHALL never be high in the same clock.
REQ-015 o_busy SHALL be a registered output, high in START, DATA, STOP and WAIT_HIGH.

Reset
REQ-016 While i_resetL=0, regardless of i_clock:
- The FSM goes to IDLE.
- o_data=0, o_valid=0, o_frame_error=0, o_busy=0, all key flags=0.
- The counters clear and the synchronizer flops are set to 1.
REQ-017 Reset asserted mid-frame SHALL discard the partial byte.
- After release, the first start edge begins a fresh frame.
- If i_RX is low when reset releases, the block does not enter START until it has seen rx_s=1 followed by rx_s=0.

Verification
REQ-018 The bench SHALL use a 1 ns clock period, drive i_RX with 434-clock bits, and cover at least these scenarios:
- Send 0x61 with stop=1 -> one-clock o_valid, o_data=0x61, o_key_a=1, other flags 0, o_frame_error never high.
- Send 0x77 then 0x00 back-to-back -> two o_valid strobes 4340 clocks apart (±2), o_key_w=1 after the first, all flags 0 after the second.
- Drive a 100-clock low glitch on idle i_RX -> no o_valid, no o_frame_error, o_busy high about 218 clocks then low.
- Send 0x55 with stop=0, hold i_RX low 1000 clocks, then high -> one o_frame_error pulse, o_data keeps its prior value, no START until i_RX is high, o_busy low only after rx_s=1.
- Assert i_resetL=0 during data bit 4 of 0x73, release, then send 0x64 -> all outputs 0 during reset, one o_valid with o_data=0x64 and o_key_d=1.
- Hold i_RX low across reset release, then raise it and send 0x73 -> no spurious frame, one o_valid with o_data=0x73 and o_key_s=1.

Source files
------------

// File: rtl/uart_receiver_with_peripheral.sv
// ---------------------------------------------------------------------------
// uart_receiver_with_peripheral
//
// 8N1-style UART receiver with a small keyboard-key decoder on the received
// byte. The serial line is synchronized into the clock domain and a
// five-state FSM samples the start bit at mid-bit and the data and stop bits
// at one-bit intervals after that. A good frame loads o_data and strobes
// o_valid. A bad stop bit strobes o_frame_error, and the receiver then waits
// for the line to return high before it looks for another start bit.
//
// Ports
//   i_clock        : single clock, rising edge
//   i_resetL       : asynchronous active-low reset
//   i_RX           : serial input, idle high, asynchronous to i_clock
//   o_data         : last correctly framed byte
//   o_valid        : one-clock strobe, new o_data
//   o_frame_error  : one-clock strobe, stop bit sampled low
//   o_busy         : registered, high whenever the FSM is not idle
//   o_key_a/s/d/w  : one-hot flags for the last decoded byte 'a','s','d','w'
// ---------------------------------------------------------------------------
`timescale 1ns/100ps

module uart_receiver_with_peripheral #(
    parameter int DATA_WIDTH          = 8,
    parameter int BIT_COUNTER_WIDTH   = 3,
    parameter int CLOCK_COUNTER_WIDTH = 21,
    parameter int CLOCKS_PER_BIT      = 434
) (
    input  logic                  i_clock,
    input  logic                  i_resetL,
    input  logic                  i_RX,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_frame_error,
    output logic                  o_busy,
    output logic                  o_key_a,
    output logic                  o_key_s,
    output logic                  o_key_d,
    output logic                  o_key_w
);

    localparam logic [CLOCK_COUNTER_WIDTH-1:0] HALF_BIT_LAST =
        CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] FULL_BIT_LAST =
        CLOCK_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);
    localparam logic [BIT_COUNTER_WIDTH-1:0] LAST_BIT =
        BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);

    localparam logic [DATA_WIDTH-1:0] KEY_A = DATA_WIDTH'(8'h61);
    localparam logic [DATA_WIDTH-1:0] KEY_S = DATA_WIDTH'(8'h73);
    localparam logic [DATA_WIDTH-1:0] KEY_D = DATA_WIDTH'(8'h64);
    localparam logic [DATA_WIDTH-1:0] KEY_W = DATA_WIDTH'(8'h77);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } state_e;

    // Key flags packed as {a, s, d, w}.
    state_e                         state_q,     state_d;
    logic                           rx_meta_q;
    logic                           rx_s_q;
    logic [1:0]                     sync_fill_q, sync_fill_d;
    logic                           armed_q,     armed_d;
    logic [CLOCK_COUNTER_WIDTH-1:0] clk_cnt_q,   clk_cnt_d;
    logic [BIT_COUNTER_WIDTH-1:0]   bit_idx_q,   bit_idx_d;
    logic [DATA_WIDTH-1:0]          shift_q,     shift_d;
    logic [DATA_WIDTH-1:0]          data_q,      data_d;
    logic                           valid_q,     valid_d;
    logic                           ferr_q,      ferr_d;
    logic                           busy_q,      busy_d;
    logic [3:0]                     keys_q,      keys_d;

    // Two-flop synchronizer. Both flops reset high, which matches an idle line.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbours and no evaluation-order race
    // exists between always_ff blocks.
    always_ff @(posedge i_clock or negedge i_resetL) begin
        if (!i_resetL) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    // The synchronizer flops read back as 1 right after reset even if the line
    // is low. sync_fill marks when rx_s carries a real sample. armed is set
    // only once such a sample has shown the line high. This stops a line that
    // is held low through reset release from being taken as a start bit.
    always_comb begin
        sync_fill_d = {sync_fill_q[0], 1'b1};
        armed_d     = armed_q | (sync_fill_q[1] & rx_s_q);
    end

    // NOTE: every signal assigned in this block gets a default first. The case
    // arms then override only what they change, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        keys_d    = keys_q;

        unique case (state_q)
            ST_IDLE: begin
                // The counter is held at zero while waiting, so it can never
                // wrap here.
                clk_cnt_d = '0;
                if (armed_q && !rx_s_q) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (clk_cnt_q == HALF_BIT_LAST) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    // A line that is high again at mid-start-bit was a glitch.
                    state_d   = rx_s_q ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (clk_cnt_q == FULL_BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[DATA_WIDTH-1:1]};  // LSB first
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end

            ST_STOP: begin
                if (clk_cnt_q == FULL_BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        case (shift_q)
                            KEY_A:   keys_d = 4'b1000;
                            KEY_S:   keys_d = 4'b0100;
                            KEY_D:   keys_d = 4'b0010;
                            KEY_W:   keys_d = 4'b0001;
                            default: keys_d = 4'b0000;
                        endcase
                        state_d = ST_IDLE;
                    end else begin
                        // o_data and the key flags keep the last good byte.
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end
                end
            end

            ST_WAIT_HIGH: begin
                clk_cnt_d = '0;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                clk_cnt_d = '0;
                state_d   = ST_IDLE;
            end
        endcase

        // Computed from the next state so that o_busy lines up with the state
        // register.
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clock or negedge i_resetL) begin
        if (!i_resetL) begin
            state_q     <= ST_IDLE;
            sync_fill_q <= '0;
            armed_q     <= 1'b0;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            busy_q      <= 1'b0;
            keys_q      <= '0;
        end else begin
            state_q     <= state_d;
            sync_fill_q <= sync_fill_d;
            armed_q     <= armed_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            busy_q      <= busy_d;
            keys_q      <= keys_d;
        end
    end

    assign o_data        = data_q;
    assign o_valid       = valid_q;
    assign o_frame_error = ferr_q;
    assign o_busy        = busy_q;
    assign o_key_a       = keys_q[3];
    assign o_key_s       = keys_q[2];
    assign o_key_d       = keys_q[1];
    assign o_key_w       = keys_q[0];

endmodule

// File: tb/tb_uart_receiver_with_peripheral.sv
// ---------------------------------------------------------------------------
// tb_uart_receiver_with_peripheral
//
// Scoreboard bench for the UART receiver. The stimulus process pushes one
// expected event into a queue for each frame it sends. A monitor on the
// falling clock edge pops an event whenever o_valid or o_frame_error is high
// and compares it. Scenario checks (latency, spacing, busy time, reset values)
// are made by the stimulus process from counters that the monitor keeps.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps

module tb_uart_receiver_with_peripheral;

    localparam int CPB = 434;

    typedef enum logic {EV_VALID = 1'b0, EV_FERR = 1'b1} ev_kind_e;
    typedef struct packed {
        ev_kind_e   kind;
        logic [7:0] data;
        logic [3:0] keys;   // {a, s, d, w}
    } ev_t;

    logic       i_clock  = 1'b0;
    logic       i_resetL = 1'b0;
    logic       i_RX     = 1'b1;
    logic [7:0] o_data;
    logic       o_valid, o_frame_error, o_busy;
    logic       o_key_a, o_key_s, o_key_d, o_key_w;

    ev_t exp_q[$];
    int  valid_time[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  cycle       = 0;
    int  valid_cnt   = 0;
    int  ferr_cnt    = 0;
    int  busy_cycles = 0;
    logic prev_valid = 1'b0;
    ev_t  mon_got, mon_exp;

    uart_receiver_with_peripheral dut (
        .i_clock       (i_clock),
        .i_resetL      (i_resetL),
        .i_RX          (i_RX),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_frame_error (o_frame_error),
        .o_busy        (o_busy),
        .o_key_a       (o_key_a),
        .o_key_s       (o_key_s),
        .o_key_d       (o_key_d),
        .o_key_w       (o_key_w)
    );

    always #0.5 i_clock = ~i_clock;

    always @(posedge i_clock) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [14:0] outs();
        return {o_data, o_valid, o_frame_error, o_busy, o_key_a, o_key_s, o_key_d, o_key_w};
    endfunction

    // Monitor: decoupled from the stimulus and driven only by DUT strobes.
    always @(negedge i_clock) begin
        if (i_resetL && o_busy) busy_cycles++;
        if (o_valid || o_frame_error) begin
            check("strobe_exclusive", {31'd0, o_valid & o_frame_error}, 32'd0);
            mon_got = '{kind: (o_valid ? EV_VALID : EV_FERR), data: o_data,
                        keys: {o_key_a, o_key_s, o_key_d, o_key_w}};
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got kind=%0d data=0x%0h at cycle %0d, expected none",
                         mon_got.kind, mon_got.data, cycle);
            end else begin
                mon_exp = exp_q.pop_front();
                check("strobe_kind", {31'd0, mon_got.kind}, {31'd0, mon_exp.kind});
                check("strobe_data", {24'd0, mon_got.data}, {24'd0, mon_exp.data});
                check("strobe_keys", {28'd0, mon_got.keys}, {28'd0, mon_exp.keys});
            end
            if (o_valid) begin
                check("valid_one_clock", {31'd0, prev_valid}, 32'd0);
                valid_cnt++;
                valid_time.push_back(cycle);
            end else begin
                ferr_cnt++;
            end
        end
        prev_valid = o_valid;
    end

    // Input changes land 0.2 ns after a rising edge, clear of the sampling edge.
    task automatic wait_clk(input int n);
        repeat (n) @(posedge i_clock);
        #0.2;
    endtask

    task automatic send_bit(input logic b);
        i_RX = b;
        wait_clk(CPB);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic expect_ev(input ev_kind_e k, input logic [7:0] d, input logic [3:0] keys);
        exp_q.push_back('{kind: k, data: d, keys: keys});
    endtask

    initial begin
        #80000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, v0, f0;

        // Reset state.
        i_resetL = 1'b0;
        i_RX     = 1'b1;
        wait_clk(5);
        check("reset_outputs", {17'd0, outs()}, 32'd0);
        i_resetL = 1'b1;
        wait_clk(20);

        // 0x61 with a good stop bit: key a, latency check.
        v0 = valid_cnt; f0 = ferr_cnt;
        expect_ev(EV_VALID, 8'h61, 4'b1000);
        t0 = cycle;
        send_byte(8'h61, 1'b1);
        wait_clk(300);
        check("a_valid_count", valid_cnt - v0, 1);
        check("a_no_ferr", ferr_cnt - f0, 0);
        if (valid_cnt > v0) check_range("a_latency", valid_time[$] - t0, 4122, 4126);

        // 0x55 with stop=0, line held low: one frame error, o_data holds 0x61.
        v0 = valid_cnt; f0 = ferr_cnt;
        expect_ev(EV_FERR, 8'h61, 4'b1000);
        send_byte(8'h55, 1'b0);
        wait_clk(1000);
        check("fe_count", ferr_cnt - f0, 1);
        check("fe_no_valid", valid_cnt - v0, 0);
        check("fe_data_held", {24'd0, o_data}, 32'h61);
        check("fe_busy_while_low", {31'd0, o_busy}, 32'd1);
        i_RX = 1'b1;
        wait_clk(1);
        check("fe_busy_before_sync", {31'd0, o_busy}, 32'd1);
        wait_clk(5);
        check("fe_busy_released", {31'd0, o_busy}, 32'd0);
        wait_clk(300);

        // 0x77 then 0x00 back-to-back.
        v0 = valid_cnt;
        expect_ev(EV_VALID, 8'h77, 4'b0001);
        expect_ev(EV_VALID, 8'h00, 4'b0000);
        send_byte(8'h77, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_clk(300);
        check("b2b_valid_count", valid_cnt - v0, 2);
        if (valid_cnt >= v0 + 2)
            check_range("b2b_spacing", valid_time[$] - valid_time[$-1], 4338, 4342);

        // 100-clock glitch on an idle line.
        v0 = valid_cnt; f0 = ferr_cnt;
        busy_cycles = 0;
        i_RX = 1'b0;
        wait_clk(100);
        i_RX = 1'b1;
        wait_clk(600);
        check_range("glitch_busy_time", busy_cycles, 215, 221);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        check("glitch_idle_after", {31'd0, o_busy}, 32'd0);

        // Line held low across reset release, then 0x73.
        i_RX = 1'b0;
        wait_clk(10);
        i_resetL = 1'b0;
        #0.1;
        check("lowrst_outputs", {17'd0, outs()}, 32'd0);
        wait_clk(5);
        i_resetL = 1'b1;
        v0 = valid_cnt; f0 = ferr_cnt;
        busy_cycles = 0;
        wait_clk(2000);
        check("lowrst_no_start", busy_cycles, 0);
        check("lowrst_no_valid", valid_cnt - v0, 0);
        check("lowrst_no_ferr", ferr_cnt - f0, 0);
        i_RX = 1'b1;
        wait_clk(CPB);
        expect_ev(EV_VALID, 8'h73, 4'b0100);
        send_byte(8'h73, 1'b1);
        wait_clk(300);
        check("lowrst_s_count", valid_cnt - v0, 1);

        // Reset during data bit 4 of 0x73, then 0x64.
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h73 >> i));
        i_RX = 1'b1;            // bit 4 of 0x73
        wait_clk(200);
        i_resetL = 1'b0;
        #0.1;
        check("midrst_outputs", {17'd0, outs()}, 32'd0);
        wait_clk(5);
        i_RX     = 1'b1;
        i_resetL = 1'b1;
        wait_clk(50);
        v0 = valid_cnt;
        expect_ev(EV_VALID, 8'h64, 4'b0010);
        send_byte(8'h64, 1'b1);
        wait_clk(300);
        check("midrst_d_count", valid_cnt - v0, 1);

        // Every expected event was consumed, nothing extra appeared.
        check("queue_drained", exp_q.size(), 0);
        check("total_valid", valid_cnt, 5);
        check("total_ferr", ferr_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
